uart_packet_controller: RTL

Parametrised successor to the fixed 8x8 RS-232 controller. Serialises a packet of NUM_WORDS words (WORD_BITS each) onto a UART TX line and, independently, deserialises NUM_WORDS words from an RX line into a parallel packet register.
- Bit period set by CLK_DIV; stop-bit count set by STOP_BITS.
- RX adds mid-bit sampling, false-start rejection and framing-error reporting.
- Sits between the parallel packet source/sink and the serial pins; loopback tx->rx is the standard bring-up configuration.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_rx_frame.sv | 134 +++++++++++++
 rtl/uart_packet_controller.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared state encodings, idle level and clog2 helper for the  |
// |               UART packet controller.                                      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package uart_pkg;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Minimum of 1 so that a degenerate value still yields a legal vector width.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_frame                                                |
// | Description : Synchronises rx and recovers one UART frame with mid-bit     |
// |               sampling; parity check enabled by UART_PARITY_EN.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int WORD_BITS = 8,
    parameter int CLK_DIV   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [WORD_BITS-1:0] word,
    output logic                 word_valid,
    output logic                 stop_err,
    output logic                 par_err
);
    localparam int TW = clog2(CLK_DIV);
    localparam int BW = clog2(WORD_BITS + 1);
    localparam logic [TW-1:0] c_timer_half = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] c_timer_max  = TW'(CLK_DIV - 1);
    localparam logic [BW-1:0] c_last_bit   = BW'(WORD_BITS - 1);

    logic [1:0]           r_sync;
    logic                 r_rx_prev;
    rx_state_t            r_state;
    logic [TW-1:0]        r_timer;
    logic [BW-1:0]        r_bit_cnt;
    logic [WORD_BITS-1:0] r_shift;
`ifdef UART_PARITY_EN
    logic                 r_par_bad;
`endif
    logic                 w_rx;

    assign w_rx = r_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync     <= {2{IDLE_LEVEL}};
            r_rx_prev  <= IDLE_LEVEL;
            r_state    <= RX_IDLE;
            r_timer    <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            stop_err   <= 1'b0;
`ifdef UART_PARITY_EN
            r_par_bad  <= 1'b0;
            par_err    <= 1'b0;
`endif
        end else begin
            r_sync     <= {r_sync[0], rx};
            r_rx_prev  <= w_rx;
            word_valid <= 1'b0;
            stop_err   <= 1'b0;
`ifdef UART_PARITY_EN
            par_err    <= 1'b0;
`endif
            case (r_state)
                // Edge-triggered arming: after a low stop bit the line must
                // return high before another frame can be detected.
                RX_IDLE: begin
                    if (r_rx_prev && !w_rx) begin
                        r_state <= RX_START;
                        r_timer <= '0;
                    end
                end
                RX_START: begin
                    if (r_timer == c_timer_half) begin
                        r_timer   <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_timer == c_timer_max) begin
                        r_timer <= '0;
                        r_shift <= {w_rx, r_shift[WORD_BITS-1:1]};
                        if (r_bit_cnt == c_last_bit) begin
`ifdef UART_PARITY_EN
                            r_state <= RX_PARITY;
`else
                            r_state <= RX_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (r_timer == c_timer_max) begin
                        r_timer   <= '0;
                        r_par_bad <= w_rx ^ (^r_shift);
                        r_state   <= RX_STOP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (r_timer == c_timer_max) begin
                        r_timer    <= '0;
                        word       <= r_shift;
                        word_valid <= 1'b1;
                        stop_err   <= !w_rx;
`ifdef UART_PARITY_EN
                        par_err    <= r_par_bad;
`endif
                        r_state    <= RX_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

`ifndef UART_PARITY_EN
    assign par_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_packet_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_packet_controller                                       |
// | Description : Packet-level UART TX serialiser and RX packet assembler;     |
// |               even parity enabled by UART_PARITY_EN.                       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module uart_packet_controller
    import uart_pkg::*;
#(
    parameter int NUM_WORDS = 8,
    parameter int WORD_BITS = 8,
    parameter int CLK_DIV   = 16,
    parameter int STOP_BITS = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start_flag,
    input  logic [NUM_WORDS*WORD_BITS-1:0] data_in,
    output logic                           tx,
    input  logic                           rx,
    output logic                           tx_busy,
    output logic                           done_flag,
    output logic [NUM_WORDS*WORD_BITS-1:0] data_out,
    output logic                           frame_err,
    output logic                           parity_err
);
    localparam int PW = NUM_WORDS * WORD_BITS;
    localparam int TW = clog2(CLK_DIV);
    localparam int BW = clog2(WORD_BITS + 1);
    localparam int IW = clog2(NUM_WORDS + 1);
    localparam logic [TW-1:0] c_timer_max = TW'(CLK_DIV - 1);
    localparam logic [BW-1:0] c_last_bit  = BW'(WORD_BITS - 1);
    localparam logic [IW-1:0] c_last_word = IW'(NUM_WORDS - 1);
    localparam bit            c_two_stops = (STOP_BITS == 2);

    tx_state_t            r_tx_state;
    logic [TW-1:0]        r_tx_timer;
    logic [BW-1:0]        r_tx_bit_cnt;
    logic [IW-1:0]        r_tx_word;
    logic [PW-1:0]        r_tx_shift;
    logic                 r_tx_stop_cnt;
`ifdef UART_PARITY_EN
    logic                 r_tx_parity;
`endif
    logic                 w_start_accept;

    logic [WORD_BITS-1:0] w_word;
    logic                 w_word_valid;
    logic                 w_stop_err;
    logic                 w_par_err;
    logic [IW-1:0]        w_slot;
    logic [PW-1:0]        w_next_shadow;
    logic [PW-1:0]        r_shadow;
    logic [IW-1:0]        r_rx_idx;

    assign w_start_accept = start_flag && (r_tx_state == TX_IDLE);

    // The whole packet shifts right one bit per data bit, so the next word is
    // already at the LSB when its start bit finishes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state    <= TX_IDLE;
            r_tx_timer    <= '0;
            r_tx_bit_cnt  <= '0;
            r_tx_word     <= '0;
            r_tx_shift    <= '0;
            r_tx_stop_cnt <= 1'b0;
`ifdef UART_PARITY_EN
            r_tx_parity   <= 1'b0;
`endif
            tx            <= IDLE_LEVEL;
            tx_busy       <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (start_flag) begin
                        r_tx_shift <= data_in;
                        r_tx_word  <= '0;
                        r_tx_timer <= '0;
                        tx         <= 1'b0;
                        tx_busy    <= 1'b1;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_timer == c_timer_max) begin
                        r_tx_timer   <= '0;
                        r_tx_bit_cnt <= '0;
                        tx           <= r_tx_shift[0];
                        r_tx_shift   <= r_tx_shift >> 1;
`ifdef UART_PARITY_EN
                        r_tx_parity  <= r_tx_shift[0];
`endif
                        r_tx_state   <= TX_DATA;
                    end else begin
                        r_tx_timer <= r_tx_timer + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (r_tx_timer == c_timer_max) begin
                        r_tx_timer <= '0;
                        if (r_tx_bit_cnt == c_last_bit) begin
`ifdef UART_PARITY_EN
                            tx         <= r_tx_parity;
                            r_tx_state <= TX_PARITY;
`else
                            tx            <= IDLE_LEVEL;
                            r_tx_stop_cnt <= 1'b0;
                            r_tx_state    <= TX_STOP;
`endif
                        end else begin
                            r_tx_bit_cnt <= r_tx_bit_cnt + 1'b1;
                            tx           <= r_tx_shift[0];
                            r_tx_shift   <= r_tx_shift >> 1;
`ifdef UART_PARITY_EN
                            r_tx_parity  <= r_tx_parity ^ r_tx_shift[0];
`endif
                        end
                    end else begin
                        r_tx_timer <= r_tx_timer + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (r_tx_timer == c_timer_max) begin
                        r_tx_timer    <= '0;
                        tx            <= IDLE_LEVEL;
                        r_tx_stop_cnt <= 1'b0;
                        r_tx_state    <= TX_STOP;
                    end else begin
                        r_tx_timer <= r_tx_timer + 1'b1;
                    end
                end
`endif
                TX_STOP: begin
                    if (r_tx_timer == c_timer_max) begin
                        r_tx_timer <= '0;
                        if (c_two_stops && !r_tx_stop_cnt) begin
                            r_tx_stop_cnt <= 1'b1;
                        end else if (r_tx_word == c_last_word) begin
                            tx         <= IDLE_LEVEL;
                            tx_busy    <= 1'b0;
                            r_tx_state <= TX_IDLE;
                        end else begin
                            r_tx_word  <= r_tx_word + 1'b1;
                            tx         <= 1'b0;
                            r_tx_state <= TX_START;
                        end
                    end else begin
                        r_tx_timer <= r_tx_timer + 1'b1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    uart_rx_frame #(
        .WORD_BITS (WORD_BITS),
        .CLK_DIV   (CLK_DIV)
    ) u_rx_frame (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .word       (w_word),
        .word_valid (w_word_valid),
        .stop_err   (w_stop_err),
        .par_err    (w_par_err)
    );

    // A frame completing on the same cycle as an accepted start lands in slot 0.
    always_comb begin
        w_slot        = w_start_accept ? '0 : r_rx_idx;
        w_next_shadow = r_shadow;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (w_slot == IW'(k)) begin
                w_next_shadow[k*WORD_BITS +: WORD_BITS] = w_word;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow   <= '0;
            r_rx_idx   <= '0;
            data_out   <= '0;
            done_flag  <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            done_flag <= 1'b0;
            if (w_start_accept) begin
                r_rx_idx   <= '0;
                frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            if (w_word_valid) begin
                r_shadow <= w_next_shadow;
                if (w_stop_err) begin
                    frame_err <= 1'b1;
                end
`ifdef UART_PARITY_EN
                if (w_par_err) begin
                    parity_err <= 1'b1;
                end
`endif
                if (w_slot == c_last_word) begin
                    data_out  <= w_next_shadow;
                    done_flag <= 1'b1;
                    r_rx_idx  <= '0;
                end else begin
                    r_rx_idx <= w_slot + 1'b1;
                end
            end
        end
    end

`ifndef UART_PARITY_EN
    assign parity_err = w_par_err;
`endif

endmodule
`default_nettype wire
